// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - UART byte input and instruction-RAM write port bundle
//
// Purpose: groups the byte stream coming from uart_rx and the write port
//          going to instruction RAM so the loader takes them as one port.
// Signals:
//   rx_valid  one-cycle pulse, rx_data holds a received byte
//   rx_data   received UART byte
//   wr_en     instruction-RAM write strobe (one cycle)
//   wr_addr   word address of the write
//   wr_data   instruction word
// Modports:
//   master    byte source / RAM sink side (drives rx_*, observes wr_*)
//   slave     loader side (observes rx_*, drives wr_*)

interface prog_loader_if #(
   parameter int ADDR_W = 8
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;

   modport master (output rx_valid, rx_data, input wr_en, wr_addr, wr_data);
   modport slave  (input rx_valid, rx_data, output wr_en, wr_addr, wr_data);
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - UART boot loader for the MIPS instruction memory
//
// Purpose: receives frames "0x55, COUNT[15:8], COUNT[7:0], COUNT*4 data bytes",
//          packs data big-endian into 32-bit words, writes them to word
//          addresses 0,1,2,... and holds the CPU in reset until the image is
//          complete or boot is skipped.
// Optional: define LOADER_CSUM_EN to append a one-byte XOR checksum of all
//           data bytes, checked in a CSUM state before the CPU is released.
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   bus        prog_loader_if.slave: rx_valid/rx_data in, wr_en/wr_addr/wr_data out
//   boot_skip  level; in SYNC, skip loading and release the CPU
//   reload     one-cycle pulse; in DONE, return to SYNC
//   cpu_hold   1 = CPU held in reset
//   busy       1 while a frame is in progress
//   err        frame error, cleared by the next sync byte
//   done       1 in DONE

module prog_loader #(
   parameter int ADDR_W         = 8,
   parameter int MAX_WORDS      = 256,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic         clk,
   input  logic         reset,
   prog_loader_if.slave bus,
   input  logic         boot_skip,
   input  logic         reload,
   output logic         cpu_hold,
   output logic         busy,
   output logic         err,
   output logic         done
);
   localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [16:0]   MAX_CNT = 17'(MAX_WORDS);
   localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_SYNC,
      S_CNT_HI,
      S_CNT_LO,
      S_DATA,
`ifdef LOADER_CSUM_EN
      S_CSUM,
`endif
      S_FIN,
      S_DONE,
      S_ERR
   } state_t;

   // State that follows the last data word (or a COUNT=0 header).
`ifdef LOADER_CSUM_EN
   localparam state_t S_TAIL = S_CSUM;
`else
   localparam state_t S_TAIL = S_FIN;
`endif

   state_t            state_q, state_nxt;
   logic [1:0]        byte_idx_q;
   logic [31:0]       word_q;
   logic              pend_q;
   logic [ADDR_W-1:0] word_idx_q;
   logic [7:0]        cnt_hi_q;
   logic [15:0]       count_q;
   logic [TW-1:0]     tcnt_q;
`ifdef LOADER_CSUM_EN
   logic [7:0]        csum_q;
`endif

   logic              wr_en_q, wr_en_nxt;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_nxt;
   logic [31:0]       wr_data_q, wr_data_nxt;
   logic              cpu_hold_q, cpu_hold_nxt;
   logic              busy_q, busy_nxt;
   logic              err_q, err_nxt;
   logic              done_q, done_nxt;

   logic        sync_byte;
   logic [15:0] count_in;
   logic        timeout_hit;
   logic        last_written;
   logic        enter_cnt_hi;
   logic        counting;

   assign sync_byte    = bus.rx_valid && (bus.rx_data == 8'h55);
   assign count_in     = {cnt_hi_q, bus.rx_data};
   assign timeout_hit  = (tcnt_q == T_LAST);
   // The final write has been on the bus for a full cycle; leave DATA now.
   assign last_written = wr_en_q &&
                         ({{(16-ADDR_W){1'b0}}, wr_addr_q} == (count_q - 16'd1));
   assign enter_cnt_hi = (state_nxt == S_CNT_HI) && (state_q != S_CNT_HI);
   assign counting     = !(state_q inside {S_SYNC, S_FIN, S_DONE, S_ERR});

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_SYNC;
      else        state_q <= state_nxt;
   end

   // Next-state logic; a byte always wins over a same-cycle timeout
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_SYNC: begin
            if (boot_skip)      state_nxt = S_DONE;
            else if (sync_byte) state_nxt = S_CNT_HI;
         end
         S_CNT_HI: begin
            if (bus.rx_valid)     state_nxt = S_CNT_LO;
            else if (timeout_hit) state_nxt = S_ERR;
         end
         S_CNT_LO: begin
            if (bus.rx_valid) begin
               if (count_in == 16'd0)               state_nxt = S_TAIL;
               else if ({1'b0, count_in} > MAX_CNT) state_nxt = S_ERR;
               else                                 state_nxt = S_DATA;
            end else if (timeout_hit) begin
               state_nxt = S_ERR;
            end
         end
         S_DATA: begin
            if (last_written)                        state_nxt = S_TAIL;
            else if (!bus.rx_valid && timeout_hit)   state_nxt = S_ERR;
         end
`ifdef LOADER_CSUM_EN
         S_CSUM: begin
            if (bus.rx_valid)     state_nxt = (bus.rx_data == csum_q) ? S_FIN : S_ERR;
            else if (timeout_hit) state_nxt = S_ERR;
         end
`endif
         S_FIN:  state_nxt = S_DONE;
         S_DONE: if (reload)    state_nxt = S_SYNC;
         S_ERR:  if (sync_byte) state_nxt = S_CNT_HI;
         default: state_nxt = S_SYNC;
      endcase
   end

   // Output logic: next values of the registered outputs
   always_comb begin
      wr_en_nxt    = pend_q;
      wr_addr_nxt  = pend_q ? word_idx_q : wr_addr_q;
      wr_data_nxt  = pend_q ? word_q     : wr_data_q;
      cpu_hold_nxt = (state_nxt != S_DONE);
      done_nxt     = (state_nxt == S_DONE);
      err_nxt      = (state_nxt == S_ERR);
      busy_nxt     = !(state_nxt inside {S_SYNC, S_FIN, S_DONE, S_ERR});
   end

   // Output registers and datapath
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         cpu_hold_q <= 1'b1;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         byte_idx_q <= '0;
         word_q     <= '0;
         pend_q     <= 1'b0;
         word_idx_q <= '0;
         cnt_hi_q   <= '0;
         count_q    <= '0;
         tcnt_q     <= '0;
`ifdef LOADER_CSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         wr_en_q    <= wr_en_nxt;
         wr_addr_q  <= wr_addr_nxt;
         wr_data_q  <= wr_data_nxt;
         cpu_hold_q <= cpu_hold_nxt;
         busy_q     <= busy_nxt;
         err_q      <= err_nxt;
         done_q     <= done_nxt;
         pend_q     <= 1'b0;

         if (bus.rx_valid || enter_cnt_hi) tcnt_q <= '0;
         else if (counting)                tcnt_q <= tcnt_q + TW'(1);
         else                              tcnt_q <= '0;

`ifdef LOADER_CSUM_EN
         if (enter_cnt_hi) csum_q <= '0;
`endif

         case (state_q)
            S_CNT_HI: if (bus.rx_valid) cnt_hi_q <= bus.rx_data;
            S_CNT_LO: begin
               if (bus.rx_valid) begin
                  count_q    <= count_in;
                  byte_idx_q <= '0;
                  word_idx_q <= '0;
               end
            end
            S_DATA: begin
               if (bus.rx_valid) begin
                  word_q     <= {word_q[23:0], bus.rx_data};
                  byte_idx_q <= byte_idx_q + 2'd1;
                  // Write is issued on the edge after the 4th byte lands
                  pend_q     <= (byte_idx_q == 2'd3);
`ifdef LOADER_CSUM_EN
                  csum_q     <= csum_q ^ bus.rx_data;
`endif
               end
               if (pend_q) word_idx_q <= word_idx_q + ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign cpu_hold    = cpu_hold_q;
   assign busy        = busy_q;
   assign err         = err_q;
   assign done        = done_q;
endmodule
